// File: rtl/mm_sched_pkg.sv
// mm_sched_pkg: shared types and sizing helpers for the matrix beat scheduler.
// Holds the scheduler state encoding plus the constant functions used to size
// the beat count and the outstanding-credit counter.
package mm_sched_pkg;

   // Sweep phases of the scheduler FSM.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Default geometry of the 8-lane multiply datapath.
   localparam int DEF_N       = 64;
   localparam int DEF_LANES   = 8;
   localparam int DEF_AW      = 14;
   localparam int DEF_MAX_OUT = 4;

   // Beats needed to cover an n x n matrix at 'lanes' addresses per beat.
   function automatic int beats(input int n, input int lanes);
      return (n * n) / lanes;
   endfunction

   // Bits needed to hold an outstanding count of 0..max_out inclusive.
   function automatic int credit_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage : mm_sched_pkg

// File: rtl/mm_credit_counter.sv
// mm_credit_counter: tracks beats accepted by the datapath but not yet
// acknowledged. inc = beat accepted, dec = acknowledge, clr = drop all credit.
// An acknowledge with nothing outstanding is ignored and flagged on underflow.
module mm_credit_counter
   import mm_sched_pkg::*;
#(
   parameter int MAX_OUT = DEF_MAX_OUT,
   parameter int CW      = credit_w(MAX_OUT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          underflow
);

   logic [CW-1:0] count_q, count_d;
   logic          inc_eff;
   logic          dec_eff;

   // An increment past MAX_OUT cannot be requested (valid is gated by full);
   // masking it here keeps the counter in range regardless of the caller.
   assign inc_eff   = inc && !full;
   assign dec_eff   = dec && (count_q != '0);
   assign full      = (count_q == CW'(MAX_OUT));
   assign underflow = dec && (count_q == '0);
   assign count     = count_q;

   // Next outstanding count: clear wins, simultaneous inc/dec cancel.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else begin
         unique case ({inc_eff, dec_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Outstanding count register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule : mm_credit_counter

// File: rtl/mm_beat_scheduler.sv
// mm_beat_scheduler: walks one N x N row-major matrix sweep as beats of LANES
// consecutive addresses, issuing them over valid/ready and limiting the number
// of unacknowledged beats to MAX_OUT. done is raised once every beat has been
// acknowledged. Optional performance counters are built when MM_SCHED_PERF_EN
// is defined; without it those ports do not exist.
module mm_beat_scheduler
   import mm_sched_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int LANES   = DEF_LANES,
   parameter int AW      = DEF_AW,
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          ready,
   input  logic          resp,
   output logic          valid,
   output logic [AW-1:0] addr_base,
   output logic          last,
   output logic          busy,
   output logic          done,
   output logic          err
`ifdef MM_SCHED_PERF_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   credit_stall_cnt
`endif
);

   localparam int            B         = beats(N, LANES);
   localparam int            CW        = credit_w(MAX_OUT);
   localparam logic [AW-1:0] LAST_ADDR = AW'((B - 1) * LANES);
   localparam logic [AW-1:0] STEP      = AW'(LANES);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          start_acc;
   logic          accept;
   logic          cnt_clr;
   logic          cnt_full;
   logic          cnt_underflow;
   logic [CW-1:0] outstanding;

   // A start is only taken while not busy, and an abort in the same cycle wins.
   assign start_acc = start && !abort && ((state_q == IDLE) || (state_q == DONE));

   // Beats are offered only while issuing and a credit is free.
   assign valid     = (state_q == ISSUE) && !cnt_full;
   assign accept    = valid && ready;
   assign last      = (state_q == ISSUE) && (addr_q == LAST_ADDR);
   assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
   assign addr_base = addr_q;
   assign done      = done_q;
   assign err       = err_q;

   // Both abort and a fresh sweep drop all outstanding credit.
   assign cnt_clr   = abort || start_acc;

   mm_credit_counter #(
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
   ) u_credit (
      .clk       (clk),
      .reset     (reset),
      .inc       (accept),
      .dec       (resp),
      .clr       (cnt_clr),
      .count     (outstanding),
      .full      (cnt_full),
      .underflow (cnt_underflow)
   );

   // Next-state logic for the sweep FSM; abort overrides every state.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (accept && last) state_d = DRAIN;
            DRAIN:   if (outstanding == '0) state_d = DONE;
            DONE:    state_d = start ? ISSUE : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Address generator and sticky done/err flags.
   always_comb begin
      addr_d = addr_q;
      done_d = done_q;
      err_d  = err_q;

      if (start_acc) begin
         addr_d = '0;
      end else if (accept && !abort) begin
         // Wraps modulo 2**AW past the final beat; never visible while valid.
         addr_d = addr_q + STEP;
      end

      if (start_acc) begin
         done_d = 1'b0;
      end else if ((state_q == DRAIN) && (outstanding == '0) && !abort) begin
         done_d = 1'b1;
      end

      if (start_acc) begin
         err_d = 1'b0;
      end else if (cnt_underflow) begin
         err_d = 1'b1;
      end
   end

   // FSM, address and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the address register is a single flop bank, not a memory, so it is reset with the rest.
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef MM_SCHED_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] cstall_q, cstall_d;

   // Saturating counts of datapath back-pressure and credit exhaustion.
   always_comb begin
      stall_d  = stall_q;
      cstall_d = cstall_q;
      if (start_acc) begin
         stall_d  = '0;
         cstall_d = '0;
      end else if (state_q == ISSUE) begin
         if (valid && !ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
         end
         if (cnt_full && (cstall_q != 32'hFFFF_FFFF)) begin
            cstall_d = cstall_q + 32'd1;
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q  <= '0;
         cstall_q <= '0;
      end else begin
         stall_q  <= stall_d;
         cstall_q <= cstall_d;
      end
   end

   assign stall_cnt        = stall_q;
   assign credit_stall_cnt = cstall_q;
`endif

endmodule : mm_beat_scheduler

// File: tb/tb_mm_beat_scheduler.sv
// tb_mm_beat_scheduler: randomized bench for mm_beat_scheduler, checked every
// cycle against a transaction-level model (beats issued, credits held, sweep
// phase flags). Build with MM_SCHED_PERF_EN to also cover the perf counters.
module tb_mm_beat_scheduler;

   localparam int N       = 64;
   localparam int LANES   = 8;
   localparam int AW      = 14;
   localparam int MAX_OUT = 4;
   localparam int B       = N * N / LANES;

   logic          clk = 1'b0;
   logic          reset, start, abort, ready, resp;
   logic          valid, last, busy, done, err;
   logic [AW-1:0] addr_base;
`ifdef MM_SCHED_PERF_EN
   logic [31:0]   stall_cnt, credit_stall_cnt;
`endif

   always #5 clk = ~clk;

   mm_beat_scheduler #(
      .N (N), .LANES (LANES), .AW (AW), .MAX_OUT (MAX_OUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .ready     (ready),
      .resp      (resp),
      .valid     (valid),
      .addr_base (addr_base),
      .last      (last),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef MM_SCHED_PERF_EN
      ,
      .stall_cnt        (stall_cnt),
      .credit_stall_cnt (credit_stall_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a sweep is a count of beats handed over plus a count
   // of credits held, with three phase flags.
   bit issuing, draining, finishing;
   int m_k, m_out, m_stall, m_cstall;
   bit m_done, m_err;
   bit last_acc;
   int cyc = 0;

   function automatic bit exp_valid();
      return issuing && (m_out < MAX_OUT);
   endfunction

   task automatic model_reset();
      issuing = 0; draining = 0; finishing = 0;
      m_k = 0; m_out = 0; m_stall = 0; m_cstall = 0;
      m_done = 0; m_err = 0; last_acc = 0;
   endtask

   task automatic check_outputs();
      check("valid", valid, exp_valid());
      check("busy", busy, issuing || draining);
      check("last", last, issuing && (m_k == B - 1));
      check("done", done, m_done);
      check("err", err, m_err);
      check("addr_base", addr_base, 64'((m_k * LANES) % (1 << AW)));
`ifdef MM_SCHED_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("credit_stall_cnt", credit_stall_cnt, m_cstall);
`endif
   endtask

   task automatic model_update(input bit st, input bit ab, input bit rd, input bit rs);
      bit acc, uf;
      acc = exp_valid() && rd;
      uf  = rs && (m_out == 0);
      if (issuing) begin
         if ((m_out < MAX_OUT) && !rd) m_stall++;
         if (m_out == MAX_OUT) m_cstall++;
      end
      if (ab) begin
         issuing = 0; draining = 0; finishing = 0; m_out = 0;
         if (uf) m_err = 1;
      end else if (st && !issuing && !draining) begin
         issuing = 1; draining = 0; finishing = 0;
         m_k = 0; m_out = 0; m_done = 0; m_err = 0; m_stall = 0; m_cstall = 0;
      end else begin
         if (uf) m_err = 1;
         if (finishing) finishing = 0;
         if (draining && (m_out == 0)) begin
            draining = 0; finishing = 1; m_done = 1;
         end
         if (acc) begin
            m_k++;
            if (m_k == B) begin
               issuing = 0; draining = 1;
            end
         end
         m_out = m_out + (acc ? 1 : 0) - ((rs && m_out > 0) ? 1 : 0);
      end
      last_acc = acc;
   endtask

   // One clock: compare outputs, drive inputs, advance model, wait an edge.
   task automatic step(input bit st, input bit ab, input bit rd, input bit rs);
      check_outputs();
      start = st; abort = ab; ready = rd; resp = rs;
      model_update(st, ab, rd, rs);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Runs the current sweep to its end. p_ready/p_resp are percentages;
   // resp_next answers each accept one cycle later; toggle alternates ready.
   task automatic finish_sweep(input int p_ready, input int p_resp, input bit resp_next,
                               input bit toggle, input bit noise, input int abort_at);
      int  guard = 0;
      bit  rd, rs, st, ab;
      bit  tog = 0;
      while ((issuing || draining || finishing) && guard < 8000) begin
         rd = toggle ? tog : ($urandom_range(0, 99) < p_ready);
         tog = ~tog;
         if (resp_next) rs = last_acc;
         else           rs = (m_out > 0) && ($urandom_range(0, 99) < p_resp);
         st = 0;
         ab = issuing && (abort_at >= 0) && (m_k == abort_at);
         if (noise) begin
            if ((issuing || draining) && $urandom_range(0, 99) < 3) st = 1;
            if ((m_out == 0) && $urandom_range(0, 199) == 0) rs = 1;
         end
         step(st, ab, rd, rs);
         guard++;
      end
      check("sweep_timeout", guard < 8000, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, lat, accepts, lasts, guard;
      model_reset();
      reset = 1'b1; start = 0; abort = 0; ready = 0; resp = 0;
      repeat (2) @(negedge clk);
      check_outputs();
      reset = 1'b0;
      @(negedge clk);

      // Full sweep, ready held, resp one cycle after each accept.
      s = cyc; lat = 0; accepts = 0; lasts = 0;
      step(1, 0, 1, 0);
      guard = 0;
      while ((issuing || draining || finishing) && guard < 2000) begin
         if (valid && last) lasts++;
         if (valid) accepts++;
         if (done === 1'b1 && lat == 0) lat = cyc - s + 1;
         step(0, 0, 1, last_acc);
         guard++;
      end
      if (done === 1'b1 && lat == 0) lat = cyc - s + 1;
      check("s1_accepts", accepts, B);
      check("s1_last_count", lasts, 1);
      check("s1_latency_ok", (lat >= 515) && (lat <= 516), 1);

      // Back-pressure then credit exhaustion with responses withheld.
      step(1, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      repeat (10) step(0, 0, 1, 0);
      check("s2_addr_frozen", addr_base, 32);
      check("s2_valid_low", valid, 0);
      step(0, 0, 1, 1);
      check("s2_valid_back", valid, 1);
      finish_sweep(70, 60, 0, 0, 0, -1);

      // Abort with three beats outstanding, late responses flag err.
      step(1, 0, 1, 0);
      guard = 0;
      while (!(m_k >= 100 && m_out == 3) && guard < 2000) begin
         step(0, 0, 1, m_out >= 3);
         guard++;
      end
      check("s3_reach_timeout", guard < 2000, 1);
      step(0, 1, 0, 0);
      check("s3_busy", busy, 0);
      check("s3_valid", valid, 0);
      check("s3_done", done, 0);
      repeat (3) step(0, 0, 0, 1);
      check("s3_err_set", err, 1);
      step(1, 0, 0, 0);
      check("s3_err_clr", err, 0);
      step(0, 1, 0, 0);

      // Asynchronous reset mid-sweep at addr_base 800.
      step(1, 0, 1, 0);
      guard = 0;
      while (m_k < 100 && guard < 4000) begin
         step(0, 0, $urandom_range(0, 3) != 0, (m_out > 0) && $urandom_range(0, 1));
         guard++;
      end
      check("s5_addr_800", addr_base, 800);
      #2 reset = 1'b1;
      start = 0; abort = 0; ready = 0; resp = 0;
      #1 model_reset();
      check_outputs();
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      step(1, 0, 1, 0);
      check("s5_restart_addr", addr_base, 0);
      finish_sweep(100, 100, 1, 0, 0, 40);

      // Random sweeps with noise: random ready/resp, stray starts and resps.
      for (int i = 0; i < 3; i++) begin
         step(1, 0, $urandom_range(0, 1), 0);
         finish_sweep($urandom_range(30, 100), $urandom_range(30, 90), 0, 0, 1,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, B - 1)) : -1);
         repeat (2) step(0, 0, 0, $urandom_range(0, 9) == 0);
      end

`ifdef MM_SCHED_PERF_EN
      // Ready toggling 0/1 from the first issue cycle: one stall per beat.
      step(1, 0, 0, 0);
      finish_sweep(0, 0, 1, 1, 0, -1);
      check("s6_stall_512", stall_cnt, B);
      step(1, 0, 0, 0);
      check("s6_stall_clr", stall_cnt, 0);
      step(0, 1, 0, 0);
`endif

      step(0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mm_beat_scheduler
